// File: rtl/seg_scan_if.sv
// Bundle between the segment encoders, seg_scan and the display pins.
//   seg_in     : active-low patterns, digit i at [8*i+7:8*i] (a..g,dp on bit7..bit0)
//   digit_en   : 1 = digit participates in the scan
//   blink      : 1 = digit goes dark during the blink-off phase
//   seg_out    : shared active-low segment bus
//   an_out     : active-low digit selects, at most one low
//   frame_done : one-cycle pulse at each frame boundary
// master = pattern source / observer, slave = seg_scan.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [NUM_DIGITS*8-1:0] seg_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;

    modport master (
        output seg_in, digit_en, blink,
        input  seg_out, an_out, frame_done
    );

    modport slave (
        input  seg_in, digit_en, blink,
        output seg_out, an_out, frame_done
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner.
// Each digit slot is a BLANK gap (all anodes off) followed by a SHOW window.
// Inputs are captured once per frame so mid-frame updates never tear.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_if.slave (seg_in, digit_en, blink in; seg_out, an_out, frame_done out)
module seg_scan #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   bus
);

    localparam int unsigned PhaseMax = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;
    localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FrameW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {StStart, StBlank, StShow} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [PhaseW-1:0]       cnt_q, cnt_d;
    logic [NUM_DIGITS*8-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [FrameW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                    frame_done_q, frame_done_d;

    logic load;
    logic frame_end;
    logic lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StStart;
            idx_q         <= '0;
            cnt_q         <= '0;
            snap_q        <= '1;
            en_q          <= '0;
            blink_q       <= '0;
            blink_phase_q <= 1'b0;
            frame_cnt_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            en_q          <= en_d;
            blink_q       <= blink_d;
            blink_phase_q <= blink_phase_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        snap_d        = snap_q;
        en_d          = en_q;
        blink_d       = blink_q;
        blink_phase_d = blink_phase_q;
        frame_cnt_d   = frame_cnt_q;
        load          = 1'b0;
        frame_end     = 1'b0;

        unique case (state_q)
            StStart: begin
                state_d = StBlank;
                idx_d   = '0;
                cnt_d   = '0;
                load    = 1'b1;
            end
            StBlank: begin
                if (cnt_q == PhaseW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StShow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShow: begin
                if (cnt_q == PhaseW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = StBlank;
                    if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
                        idx_d     = '0;
                        load      = 1'b1;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StStart;
        endcase

        // Frame-boundary capture keeps the whole frame consistent.
        if (load) begin
            snap_d  = bus.seg_in;
            en_d    = bus.digit_en;
            blink_d = bus.blink;
        end

        // The toggled phase lands during the first BLANK, so it governs the
        // first SHOW of the new frame.
        if (frame_end) begin
            if (frame_cnt_q == FrameW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // Pulse covers exactly the first BLANK cycle of each new frame.
        frame_done_d = frame_end;
    end

    // Outputs decode registers only; no input reaches an output combinationally.
    always_comb begin
        lit = (state_q == StShow) && en_q[idx_q] && !(blink_q[idx_q] && blink_phase_q);
        bus.seg_out    = 8'hFF;
        bus.an_out     = '1;
        bus.frame_done = frame_done_q;
        if (lit) begin
            bus.seg_out        = snap_q[8*idx_q +: 8];
            bus.an_out[idx_q]  = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Randomized self-checking bench for seg_scan against a frame-arithmetic model.
module tb_seg_scan;

    localparam int unsigned N      = 2;
    localparam int unsigned DIV    = 4;
    localparam int unsigned BLANK  = 1;
    localparam int unsigned BFR    = 2;
    localparam int unsigned SLOT   = BLANK + DIV;
    localparam int unsigned PERIOD = N * SLOT;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seg_scan #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (DIV),
        .BLANK_CYCLES(BLANK),
        .BLINK_FRAMES(BFR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: t = cycles since reset release (0 = START cycle).
    int           t = 0;
    logic [N*8-1:0] m_seg;
    logic [N-1:0]   m_en;
    logic [N-1:0]   m_blink;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_seg_out", 32'(bus.seg_out), 32'hFF);
        check_eq("rst_an_out", 32'(bus.an_out), 32'h3);
        check_eq("rst_frame_done", 32'(bus.frame_done), 32'h0);
    endtask

    task automatic check_outputs();
        logic [7:0]   e_seg;
        logic [N-1:0] e_an;
        logic         e_fd;
        int pos, f, d, w;
        logic lit;
        e_seg = 8'hFF;
        e_an  = '1;
        e_fd  = 1'b0;
        if (t > 0) begin
            pos  = (t - 1) % PERIOD;
            f    = (t - 1) / PERIOD;
            d    = pos / SLOT;
            w    = pos % SLOT;
            e_fd = (pos == 0) && (f > 0);
            lit  = (w >= BLANK) && m_en[d] && !(m_blink[d] && ((f / BFR) % 2 == 1));
            if (lit) begin
                e_seg   = m_seg[8*d +: 8];
                e_an[d] = 1'b0;
            end
        end
        check_eq("seg_out", 32'(bus.seg_out), 32'(e_seg));
        check_eq("an_out", 32'(bus.an_out), 32'(e_an));
        check_eq("frame_done", 32'(bus.frame_done), 32'(e_fd));
        check_eq("an_onehot", 32'($countones(~bus.an_out) <= 1), 32'h1);
    endtask

    task automatic step();
        @(posedge clk);
        if (t == 0 || ((t - 1) % PERIOD) == PERIOD - 1) begin
            m_seg   = bus.seg_in;
            m_en    = bus.digit_en;
            m_blink = bus.blink;
        end
        t++;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Async assert is checked before any clock edge; release lands on a negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset_outputs();
        end
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        #1;
        check_outputs();
    endtask

    task automatic randomize_inputs();
        if ($urandom_range(0, 3) == 0) bus.seg_in   = 16'($urandom);
        if ($urandom_range(0, 7) == 0) bus.digit_en = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) bus.blink    = 2'($urandom_range(0, 3));
    endtask

    initial begin
        bus.seg_in   = 16'h9F03;
        bus.digit_en = 2'b11;
        bus.blink    = 2'b00;
        m_seg   = '1;
        m_en    = '0;
        m_blink = '0;
        #2;
        do_reset();

        // Steady scan, then a mid-frame change during digit 0 SHOW.
        run(PERIOD + 2);
        bus.seg_in[7:0] = 8'h25;
        run(2 * PERIOD);

        // Digit 1 disabled.
        bus.digit_en = 2'b01;
        run(2 * PERIOD);

        // Blink on digit 1, counted from a fresh reset.
        bus.digit_en = 2'b11;
        bus.blink    = 2'b10;
        do_reset();
        run(6 * PERIOD);

        // Random inputs changing at arbitrary points in the frame.
        for (int i = 0; i < 40 * PERIOD; i++) begin
            step();
            randomize_inputs();
        end

        // Async reset dropped mid-SHOW of digit 0.
        bus.digit_en = 2'b11;
        bus.blink    = 2'b00;
        while (((t - 1) % PERIOD) != BLANK + 1) step();
        #3;
        do_reset();
        for (int i = 0; i < 10 * PERIOD; i++) begin
            step();
            randomize_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
